iterative_alu: RTL and testbench

- Parametrised, handshaked successor to the combinational ALU in the execute stage.
- Single-cycle ops (set, arithmetic, logic, shift, compare, abs) complete in 1 cycle.
- Multiply and divide/remainder run as DATA_WIDTH-cycle iterative shift-add / restoring-divide sequences.
- Adds correct signed overflow, shift saturation, illegal-op and divide-by-zero flags, and output back-pressure.

---
 rtl/iterative_alu.sv | 203 ++++++++++++++++++++
 tb/tb_iterative_alu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Handshaked execute-stage ALU. Single-cycle ops finish in one cycle. Multiply and
// divide/remainder iterate one bit per cycle over DATA_WIDTH cycles.
module iterative_alu #(
    parameter int DATA_WIDTH = 16,
    parameter int FUNC_WIDTH = 5,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  _clock,
    input  logic                  _resetN,
    input  logic                  _inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] _valA,
    input  logic [DATA_WIDTH-1:0] _valB,
    input  logic [FUNC_WIDTH-1:0] _funcCode,
    output logic                  outValid,
    input  logic                  _outReady,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  compareBit,
    output logic                  divZero,
    output logic                  illegalOp,
    output logic                  busy
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [FUNC_WIDTH-1:0] OP_SET  = FUNC_WIDTH'('h00);
    localparam logic [FUNC_WIDTH-1:0] OP_ADD  = FUNC_WIDTH'('h01);
    localparam logic [FUNC_WIDTH-1:0] OP_SUB  = FUNC_WIDTH'('h02);
    localparam logic [FUNC_WIDTH-1:0] OP_SLL  = FUNC_WIDTH'('h03);
    localparam logic [FUNC_WIDTH-1:0] OP_SRL  = FUNC_WIDTH'('h04);
    localparam logic [FUNC_WIDTH-1:0] OP_SRA  = FUNC_WIDTH'('h05);
    localparam logic [FUNC_WIDTH-1:0] OP_AND  = FUNC_WIDTH'('h06);
    localparam logic [FUNC_WIDTH-1:0] OP_OR   = FUNC_WIDTH'('h07);
    localparam logic [FUNC_WIDTH-1:0] OP_XOR  = FUNC_WIDTH'('h08);
    localparam logic [FUNC_WIDTH-1:0] OP_NOT  = FUNC_WIDTH'('h09);
    localparam logic [FUNC_WIDTH-1:0] OP_LSS  = FUNC_WIDTH'('h0A);
    localparam logic [FUNC_WIDTH-1:0] OP_EQL  = FUNC_WIDTH'('h0B);
    localparam logic [FUNC_WIDTH-1:0] OP_GRT  = FUNC_WIDTH'('h0C);
    localparam logic [FUNC_WIDTH-1:0] OP_ABS  = FUNC_WIDTH'('h0D);
    localparam logic [FUNC_WIDTH-1:0] OP_MUL  = FUNC_WIDTH'('h0E);
    localparam logic [FUNC_WIDTH-1:0] OP_MULH = FUNC_WIDTH'('h0F);
    localparam logic [FUNC_WIDTH-1:0] OP_DIV  = FUNC_WIDTH'('h10);
    localparam logic [FUNC_WIDTH-1:0] OP_REM  = FUNC_WIDTH'('h11);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH-1:0] hi_q, lo_q, b_q, result_q;
    logic [FUNC_WIDTH-1:0] func_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  div_zero_q, ovf_q, cmp_q, dz_q, ill_q;

    // Single-cycle datapath, evaluated directly on the request inputs.
    logic [DATA_WIDTH-1:0] sum, diff, neg_a, sc_result;
    logic [CNT_WIDTH-1:0]  shamt;
    logic                  shift_big, div_op, iter_op, sc_ovf, sc_cmp, sc_illegal;

    assign sum       = _valA + _valB;
    assign diff      = _valA - _valB;
    assign neg_a     = '0 - _valA;
    assign shift_big = _valB >= DATA_WIDTH'(DATA_WIDTH);
    assign shamt     = _valB[CNT_WIDTH-1:0];
    assign div_op    = (_funcCode == OP_DIV) || (_funcCode == OP_REM);
    assign iter_op   = div_op || (_funcCode == OP_MUL) || (_funcCode == OP_MULH);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_cmp     = 1'b0;
        sc_illegal = 1'b0;
        case (_funcCode)
            OP_SET:  sc_result = _valA;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (_valA[MSB] == _valB[MSB]) && (sum[MSB] != _valA[MSB]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (_valA[MSB] != _valB[MSB]) && (diff[MSB] != _valA[MSB]);
            end
            OP_SLL:  sc_result = shift_big ? '0 : _valA << shamt;
            OP_SRL:  sc_result = shift_big ? '0 : _valA >> shamt;
            OP_SRA:  sc_result = shift_big ? {DATA_WIDTH{_valA[MSB]}} : $signed(_valA) >>> shamt;
            OP_AND:  sc_result = _valA & _valB;
            OP_OR:   sc_result = _valA | _valB;
            OP_XOR:  sc_result = _valA ^ _valB;
            OP_NOT:  sc_result = ~_valA;
            OP_LSS:  sc_cmp = $signed(_valA) < $signed(_valB);
            OP_EQL:  sc_cmp = _valA == _valB;
            OP_GRT:  sc_cmp = $signed(_valA) > $signed(_valB);
            OP_ABS: begin
                sc_result = _valA[MSB] ? neg_a : _valA;
                sc_ovf    = _valA == MIN_NEG;
            end
            OP_MUL, OP_MULH, OP_DIV, OP_REM: sc_result = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Iterative datapath: hi/lo hold {product high, multiplier} or {remainder, quotient}.
    logic [DATA_WIDTH:0]   mul_sum, div_shift;
    logic                  div_ge, mul_mode, take_high, last_step;
    logic [DATA_WIDTH-1:0] step_hi, step_lo, final_result;

    assign mul_mode  = (func_q == OP_MUL) || (func_q == OP_MULH);
    assign take_high = (func_q == OP_MULH) || (func_q == OP_REM);
    assign last_step = cnt_q == CNT_WIDTH'(1);
    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    assign div_shift = {hi_q, lo_q[MSB]};
    assign div_ge    = div_shift >= {1'b0, b_q};

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        if (!div_zero_q) begin
            if (mul_mode) begin
                step_hi = mul_sum[DATA_WIDTH:1];
                step_lo = {mul_sum[0], lo_q[MSB:1]};
            end else begin
                step_hi = div_ge ? div_shift[DATA_WIDTH-1:0] - b_q : div_shift[DATA_WIDTH-1:0];
                step_lo = {lo_q[MSB-1:0], div_ge};
            end
        end
    end

    assign final_result = take_high ? step_hi : step_lo;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (_inValid) state_next = iter_op ? BUSY : DONE;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (_outReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge _clock) begin
        if (!_resetN) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge _clock) begin
        if (!_resetN) begin
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            func_q     <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            cmp_q      <= 1'b0;
            dz_q       <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (_inValid) begin
                    b_q        <= _valB;
                    func_q     <= _funcCode;
                    cnt_q      <= CNT_WIDTH'(DATA_WIDTH);
                    result_q   <= sc_result;
                    ovf_q      <= sc_ovf;
                    cmp_q      <= sc_cmp;
                    ill_q      <= sc_illegal;
                    dz_q       <= 1'b0;
                    div_zero_q <= div_op && (_valB == '0);
                    // A zero divisor preloads the final answer and then idles through the count.
                    hi_q       <= '0;
                    lo_q       <= _valA;
                    if (div_op && (_valB == '0)) begin
                        hi_q <= _valA;
                        lo_q <= '1;
                    end
                end
                BUSY: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                    if (last_step) begin
                        result_q <= final_result;
                        dz_q     <= div_zero_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inReady    = state == IDLE;
    assign busy       = state == BUSY;
    assign outValid   = state == DONE;
    assign result     = result_q;
    assign overflow   = ovf_q;
    assign compareBit = cmp_q;
    assign divZero    = dz_q;
    assign illegalOp  = ill_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed scoreboard bench for iterative_alu (DATA_WIDTH=16): expectations come
// from a behavioural model pushed at issue time and popped when outValid rises.
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [4:0]  code = '0;
    logic        in_ready, out_valid, overflow, compare_bit, div_zero, illegal_op, busy;
    logic [15:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        ovf, cmp, dz, ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    iterative_alu #(.DATA_WIDTH(16), .FUNC_WIDTH(5)) dut (
        ._clock(clk), ._resetN(rst_n), ._inValid(in_valid), .inReady(in_ready),
        ._valA(a), ._valB(b), ._funcCode(code), .outValid(out_valid),
        ._outReady(out_ready), .result(result), .overflow(overflow),
        .compareBit(compare_bit), .divZero(div_zero), .illegalOp(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(string tag, logic [4:0] op, logic [15:0] x, logic [15:0] y);
        exp_t        e;
        int          sx = $signed(x);
        int          sy = $signed(y);
        int          s;
        logic [31:0] p;
        logic [15:0] r;
        e.tag = tag; e.res = '0; e.ovf = 0; e.cmp = 0; e.dz = 0; e.ill = 0; e.lat = 1;
        p = {16'd0, x} * {16'd0, y};
        case (op)
            5'h00: e.res = x;
            5'h01: begin s = sx + sy; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            5'h02: begin s = sx - sy; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            5'h03: begin r = x; for (int i = 0; i < int'(y) && i < 16; i++) r = r << 1; e.res = r; end
            5'h04: begin r = x; for (int i = 0; i < int'(y) && i < 16; i++) r = r >> 1; e.res = r; end
            5'h05: begin r = x; for (int i = 0; i < int'(y) && i < 16; i++) r = {r[15], r[15:1]}; e.res = r; end
            5'h06: e.res = x & y;
            5'h07: e.res = x | y;
            5'h08: e.res = x ^ y;
            5'h09: e.res = ~x;
            5'h0A: e.cmp = sx < sy;
            5'h0B: e.cmp = x == y;
            5'h0C: e.cmp = sx > sy;
            5'h0D: begin s = (sx < 0) ? -sx : sx; e.res = s[15:0]; e.ovf = s > 32767; end
            5'h0E: begin e.res = p[15:0];  e.lat = 17; end
            5'h0F: begin e.res = p[31:16]; e.lat = 17; end
            5'h10: begin e.lat = 17; e.dz = (y == 0); e.res = (y == 0) ? 16'hFFFF : x / y; end
            5'h11: begin e.lat = 17; e.dz = (y == 0); e.res = (y == 0) ? x : x % y; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Drives one request; the accept edge is the posedge this task waits for.
    task automatic issue(string tag, logic [4:0] op, logic [15:0] x, logic [15:0] y);
        sb.push_back(model(tag, op, x, y));
        check({tag, "/in_ready_before"}, in_ready, 1);
        in_valid = 1'b1; code = op; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect();
        int   lat = 1;
        int   busy_n = 0;
        logic ir_seen;
        exp_t e;
        ir_seen = in_ready;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
            ir_seen = ir_seen | in_ready;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "/latency"}, lat, e.lat);
        check({e.tag, "/busy_cycles"}, busy_n, e.lat - 1);
        check({e.tag, "/in_ready_low"}, ir_seen, 0);
        check({e.tag, "/result"}, result, e.res);
        check({e.tag, "/overflow"}, overflow, e.ovf);
        check({e.tag, "/compare"}, compare_bit, e.cmp);
        check({e.tag, "/div_zero"}, div_zero, e.dz);
        check({e.tag, "/illegal"}, illegal_op, e.ill);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("consume/out_valid", out_valid, 0);
        check("consume/in_ready", in_ready, 1);
    endtask

    task automatic run(string tag, logic [4:0] op, logic [15:0] x, logic [15:0] y);
        issue(tag, op, x, y);
        collect();
        consume();
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("reset/in_ready", in_ready, 1);
        check("reset/out_valid", out_valid, 0);
        check("reset/busy", busy, 0);
        check("reset/result", result, 0);
        check("reset/flags", {overflow, compare_bit, div_zero, illegal_op}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("add_ovf", 5'h01, 16'h7FFF, 16'h0001);
        run("sub_ovf", 5'h02, 16'h8000, 16'h0001);
        run("add_plain", 5'h01, 16'h1234, 16'h0F0F);
        run("mul", 5'h0E, 16'hFFFF, 16'hFFFF);
        run("mulh", 5'h0F, 16'hFFFF, 16'hFFFF);
        run("div", 5'h10, 16'd100, 16'd7);
        run("rem", 5'h11, 16'd100, 16'd7);
        run("div_zero", 5'h10, 16'h1234, 16'h0000);
        run("rem_zero", 5'h11, 16'h1234, 16'h0000);
        run("srl", 5'h04, 16'h8000, 16'd4);
        run("sra_big", 5'h05, 16'h8000, 16'd20);
        run("sll_16", 5'h03, 16'h0001, 16'd16);
        run("sra_zero", 5'h05, 16'h8001, 16'd0);
        run("abs_min", 5'h0D, 16'h8000, 16'h0000);
        run("abs_neg", 5'h0D, 16'hFFF3, 16'h0000);
        run("grt", 5'h0C, 16'h0005, 16'hFFFE);
        run("not", 5'h09, 16'hA5A5, 16'h0000);
        run("illegal", 5'h1F, 16'h1234, 16'h5678);

        // Back-pressure: result held while a competing request is presented.
        out_ready = 1'b0;
        issue("lss_bp", 5'h0A, 16'hFFFF, 16'h0001);
        collect();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; code = 5'h01; a = 16'h0001; b = 16'h0001;
            @(posedge clk); #1;
            check("bp/out_valid", out_valid, 1);
            check("bp/in_ready", in_ready, 0);
            check("bp/hold", {compare_bit, result}, {1'b1, 16'h0000});
        end
        in_valid = 1'b0;
        consume();
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("bp/ignored_request", seen, 0);

        // Reset during the eighth busy cycle of a divide.
        issue("div_rst", 5'h10, 16'h1234, 16'h0007);
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("rst_mid/busy_before", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid/in_ready", in_ready, 1);
        check("rst_mid/outputs", {out_valid, busy, overflow, compare_bit, div_zero, illegal_op, result}, 0);
        rst_n = 1'b1;
        sb.delete();
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("rst_mid/no_result", seen, 0);

        for (int i = 0; i < 8; i++) begin
            logic [4:0]  op;
            logic [15:0] x, y;
            op = 5'($urandom_range(0, 19));
            x  = 16'($urandom);
            y  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            run($sformatf("rand%0d_op%0h", i, op), op, x, y);
        end

        check("scoreboard/empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
